// File: rtl/ibex_tb_mem_pkg.sv
// Shared types for the tagged memory responder: response payload, grant FSM
// states and the upper bound on response latency.
package ibex_tb_mem_pkg;

    // Deepest response pipeline the responder supports.
    localparam int unsigned MaxRspLatency = 8;

    // One response beat: error flag plus {tag, data}.
    typedef struct packed {
        logic        err;
        logic [32:0] rdata;
    } mem_rsp_t;

    // Grant FSM states.
    typedef enum logic {
        GntIdle = 1'b0,
        GntWait = 1'b1
    } gnt_state_e;

endpackage

// File: rtl/ibex_tb_mem_rsp_pipe.sv
// Valid/payload delay line of fixed depth. Valids are cleared by srst; the
// payload registers only load behind a valid and are never reset, since
// consumers qualify the payload with out_valid.
module ibex_tb_mem_rsp_pipe #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);

    genvar gi;

    generate
        for (gi = 0; gi < Depth; gi++) begin : g_stage
            logic             valid_reg;
            logic [Width-1:0] data_reg;
            logic             prev_valid;
            logic [Width-1:0] prev_data;

            if (gi == 0) begin : g_src
                assign prev_valid = in_valid;
                assign prev_data  = in_data;
            end else begin : g_src
                assign prev_valid = g_stage[gi-1].valid_reg;
                assign prev_data  = g_stage[gi-1].data_reg;
            end

            // Shift one stage per cycle; reset drops everything in flight.
            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= prev_valid;
                end
                if (prev_valid) begin
                    data_reg <= prev_data;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[Depth-1].valid_reg;
    assign out_data  = g_stage[Depth-1].data_reg;

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao SECDED (39,32) encoder: data passes through unchanged,
// seven check bits are appended, with check bits 1, 3 and 5 inverted so an
// all-zero word never encodes to an all-zero codeword.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    // Parity of each check column, then the fixed inversion pattern.
    always_comb begin : p_encode
        data_o       = {7'h00, data_i};
        data_o[32]   = ^(data_i & 32'h2606_BD25);
        data_o[33]   = ^(data_i & 32'hDEBA_8050);
        data_o[34]   = ^(data_i & 32'h413D_89AA);
        data_o[35]   = ^(data_i & 32'h3123_4ED1);
        data_o[36]   = ^(data_i & 32'hC2C1_323B);
        data_o[37]   = ^(data_i & 32'h2DCC_624C);
        data_o[38]   = ^(data_i & 32'h9850_5586);
        data_o[38:32] = data_o[38:32] ^ 7'h2A;
    end

endmodule

// File: rtl/ibex_tagged_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid protocol with 33-bit
// tagged words (bit 32 = capability tag). Word-addressed byte-lane SRAM plus
// a resettable tag array, a configurable grant stall and a fixed-latency,
// in-order response pipeline.
module ibex_tagged_mem_responder
    import ibex_tb_mem_pkg::*;
#(
    parameter int unsigned Depth      = 1024,
    parameter logic [31:0] AddrBase   = 32'h8000_0000,
    parameter int unsigned GntStall   = 0,
    parameter int unsigned RspLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [32:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic        rvalid_o,
    output logic [32:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o
);

    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = (GntStall > 1) ? $clog2(GntStall) : 1;
    // Latency is clamped into 1..MaxRspLatency so a bad override still builds.
    localparam int unsigned PipeDepth = (RspLatency < 1) ? 1 :
                                        (RspLatency > MaxRspLatency) ? MaxRspLatency :
                                        RspLatency;
    localparam logic [32:0]     SpanBytes = 33'(Depth) << 2;
    localparam logic [CntW-1:0] CntReload = CntW'(GntStall - 1);
    localparam int unsigned     RspW      = $bits(mem_rsp_t);

    genvar gi;

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    gnt_state_e      state_reg, state_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic            gnt;

    // State and stall counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= GntIdle;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and grant: zero stall grants straight from idle, otherwise
    // each request waits GntStall cycles; stall_i only blocks the final grant.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt        = 1'b0;
        case (state_reg)
            GntIdle: begin
                if (GntStall == 0) begin
                    gnt = req_i & ~stall_i;
                end else if (req_i) begin
                    state_next = GntWait;
                    cnt_next   = CntReload;
                end
            end
            GntWait: begin
                if (!req_i) begin
                    state_next = GntIdle;
                    cnt_next   = '0;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CntW'(1);
                end else if (!stall_i) begin
                    gnt        = 1'b1;
                    state_next = GntIdle;
                end
            end
            default: begin
                state_next = GntIdle;
                cnt_next   = '0;
            end
        endcase
    end

    assign gnt_o = gnt;

    // ------------------------------------------------------------------
    // Address decode and request checks
    // ------------------------------------------------------------------
    logic [31:0]   offset;
    logic          in_range;
    logic [IdxW-1:0] idx;
    logic [38:0]   wdata_enc;
    logic          intg_ok;
    logic          req_err;
    logic          access;
    logic          wr_en;

    assign offset   = addr_i - AddrBase;
    assign in_range = (addr_i >= AddrBase) && ({1'b0, offset} < SpanBytes);
    assign idx      = offset[IdxW+1:2];

    prim_secded_inv_39_32_enc u_wdata_enc (
        .data_i (wdata_i[31:0]),
        .data_o (wdata_enc)
    );

    assign intg_ok = (wdata_enc[38:32] == wdata_intg_i);
    assign req_err = ~in_range | (we_i & ~intg_ok);
    // A grant that coincides with reset is discarded entirely.
    assign access  = gnt & ~rst_i;
    assign wr_en   = access & we_i & ~req_err;

    // ------------------------------------------------------------------
    // Storage: one RAM per byte lane, tags in flops so reset can clear them
    // ------------------------------------------------------------------
    logic [31:0]      rd_word;
    logic [Depth-1:0] tag_reg;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [Depth];

            // Byte-lane write at the grant edge.
            always_ff @(posedge clk_i) begin
                if (wr_en && be_i[gi]) begin
                    lane_mem[idx] <= wdata_i[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[idx];
        end
    endgenerate

    // Tag update: a full-word write stores the tag, any partial write
    // invalidates it, an empty byte mask leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_reg <= '0;
        end else if (wr_en) begin
            if (be_i == 4'hF) begin
                tag_reg[idx] <= wdata_i[32];
            end else if (be_i != 4'h0) begin
                tag_reg[idx] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    mem_rsp_t        rsp_in;
    mem_rsp_t        rsp_out;
    logic [RspW-1:0] rsp_out_bits;
    logic            pipe_valid;

    // Payload captured at the grant edge: read data for good reads, zero
    // for writes and errors. The first pipe stage is the RAM read register.
    always_comb begin
        rsp_in     = '0;
        rsp_in.err = req_err;
        if (!req_err && !we_i) begin
            rsp_in.rdata = {tag_reg[idx], rd_word};
        end
    end

    ibex_tb_mem_rsp_pipe #(
        .Depth (PipeDepth),
        .Width (RspW)
    ) u_rsp_pipe (
        .clk       (clk_i),
        .srst      (rst_i),
        .in_valid  (access),
        .in_data   (rsp_in),
        .out_valid (pipe_valid),
        .out_data  (rsp_out_bits)
    );

    assign rsp_out  = mem_rsp_t'(rsp_out_bits);
    assign rvalid_o = pipe_valid;
    assign err_o    = pipe_valid & rsp_out.err;
    assign rdata_o  = pipe_valid ? rsp_out.rdata : 33'h0;

    logic [38:0] rdata_enc;

    prim_secded_inv_39_32_enc u_rdata_enc (
        .data_i (rdata_o[31:0]),
        .data_o (rdata_enc)
    );

    assign rdata_intg_o = rdata_enc[38:32];

    // Address byte offset, decode bits above the index and the pass-through
    // halves of the encoders carry no information here.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], offset[31:IdxW+2], wdata_enc[31:0], rdata_enc[31:0]};

endmodule

// File: tb/tb_ibex_tagged_mem_responder.sv
// Bench for ibex_tagged_mem_responder. Three instances: A (no stall,
// latency 1) and C (no stall, latency 3) share one request stream and a
// behavioural memory model; B (stall 2, latency 3) is used for grant timing.
module tb_ibex_tagged_mem_responder;

    localparam logic [31:0] Base   = 32'h8000_0000;
    localparam int          NWords = 1024;
    localparam logic [31:0] HCol [7] = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA,
                                         32'h3123_4ED1, 32'hC2C1_323B, 32'h2DCC_624C,
                                         32'h9850_5586};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, stall;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic [6:0]  wintg;
    logic        req_b, stall_b;
    logic [31:0] addr_b;

    logic        gnt_a, rvalid_a, err_a;
    logic [32:0] rdata_a;
    logic [6:0]  rintg_a;
    logic        gnt_c, rvalid_c, err_c;
    logic [32:0] rdata_c;
    logic [6:0]  rintg_c;
    logic        gnt_b, rvalid_b, err_b;
    logic [32:0] rdata_b;
    logic [6:0]  rintg_b;

    ibex_tagged_mem_responder #(.Depth(NWords), .AddrBase(Base), .GntStall(0), .RspLatency(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req), .gnt_o(gnt_a), .we_i(we),
        .be_i(be), .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .rdata_intg_o(rintg_a), .err_o(err_a));

    ibex_tagged_mem_responder #(.Depth(NWords), .AddrBase(Base), .GntStall(0), .RspLatency(3)) dut_c (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req), .gnt_o(gnt_c), .we_i(we),
        .be_i(be), .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .rvalid_o(rvalid_c),
        .rdata_o(rdata_c), .rdata_intg_o(rintg_c), .err_o(err_c));

    ibex_tagged_mem_responder #(.Depth(NWords), .AddrBase(Base), .GntStall(2), .RspLatency(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall_b), .req_i(req_b), .gnt_o(gnt_b), .we_i(we),
        .be_i(be), .addr_i(addr_b), .wdata_i(wdata), .wdata_intg_i(wintg), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .rdata_intg_o(rintg_b), .err_o(err_b));

    typedef struct {
        int          due;
        logic        err;
        logic [32:0] rdata;
    } exp_t;

    exp_t        qa[$];
    exp_t        qc[$];
    logic [31:0] mem_m [NWords];
    bit          tag_m [NWords];
    int          cyc, n_cmp, n_bad;

    logic        b_gnt_s, b_rvalid_s, b_err_s;
    logic [32:0] b_rdata_s;
    logic [6:0]  b_intg_s;

    function automatic logic [6:0] enc7(input logic [31:0] d);
        logic [6:0] c;
        for (int k = 0; k < 7; k++) c[k] = ^(d & HCol[k]);
        return c ^ 7'h2A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string nm, input bit due, input exp_t e, input logic rv,
                           input logic er, input logic [32:0] rd, input logic [6:0] ri);
        chk({nm, "_rvalid"}, 64'(rv), 64'(due));
        chk({nm, "_err"},    64'(er), 64'(due ? e.err : 1'b0));
        chk({nm, "_rdata"},  64'(rd), 64'(due ? e.rdata : 33'h0));
        chk({nm, "_rintg"},  64'(ri), 64'(enc7(due ? e.rdata[31:0] : 32'h0)));
    endtask

    // Mid-cycle: compare every A/C output with the model, sample B.
    task automatic check_outputs();
        exp_t e;
        bit   due;
        e = '{due: 0, err: 1'b0, rdata: 33'h0};
        chk("gnt_a", 64'(gnt_a), 64'(req & ~stall));
        chk("gnt_c", 64'(gnt_c), 64'(req & ~stall));
        due = (qa.size() > 0) && (qa[0].due == cyc);
        chk_rsp("a", due, due ? qa[0] : e, rvalid_a, err_a, rdata_a, rintg_a);
        if (due) void'(qa.pop_front());
        due = (qc.size() > 0) && (qc[0].due == cyc);
        chk_rsp("c", due, due ? qc[0] : e, rvalid_c, err_c, rdata_c, rintg_c);
        if (due) void'(qc.pop_front());
        b_gnt_s    = gnt_b;
        b_rvalid_s = rvalid_b;
        b_err_s    = err_b;
        b_rdata_s  = rdata_b;
        b_intg_s   = rintg_b;
    endtask

    // Apply what the coming clock edge does to the memory and response model.
    task automatic update_model();
        exp_t e;
        bit   inr, bad;
        int   idx;
        if (rst) begin
            qa.delete();
            qc.delete();
            for (int i = 0; i < NWords; i++) tag_m[i] = 1'b0;
            return;
        end
        if (!(req && !stall)) return;
        inr = (longint'(addr) >= longint'(Base)) && (longint'(addr) < longint'(Base) + 4 * NWords);
        idx = inr ? int'((addr - Base) >> 2) : 0;
        bad = !inr || (we && (wintg !== enc7(wdata[31:0])));
        e.err   = bad;
        e.rdata = 33'h0;
        if (!bad) begin
            if (we) begin
                for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                if (be == 4'hF) tag_m[idx] = wdata[32];
                else if (be != 4'h0) tag_m[idx] = 1'b0;
            end else begin
                e.rdata = {tag_m[idx], mem_m[idx]};
            end
        end
        $display("txn cyc=%0d %s addr=%08h be=%h wdata=%09h -> err=%0d rdata=%09h",
                 cyc, we ? "WR" : "RD", addr, be, wdata, e.err, e.rdata);
        e.due = cyc + 1;
        qa.push_back(e);
        e.due = cyc + 3;
        qc.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit r, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [32:0] d, input logic [6:0] flip);
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
        wintg = enc7(d[31:0]) ^ flip;
        tick();
    endtask

    initial begin
        int          gc, rc, sel;
        logic [31:0] ra;
        rst = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0; be = 4'h0; addr = Base;
        wdata = 33'h0; wintg = enc7(32'h0);
        req_b = 1'b0; stall_b = 1'b0; addr_b = 32'h0000_0100;
        cyc = 0; n_cmp = 0; n_bad = 0;
        @(posedge clk);
        #1;
        tick();
        // Reset state
        chk("rst_rvalid_a", 64'(rvalid_a), 64'(0));
        chk("rst_rdata_a",  64'(rdata_a),  64'(0));
        chk("rst_err_a",    64'(err_a),    64'(0));
        chk("rst_rvalid_b", 64'(rvalid_b), 64'(0));
        chk("rst_gnt_b",    64'(gnt_b),    64'(0));
        rst = 1'b0;

        // Fill words 0..15 so every later read has defined contents.
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b1, 4'hF, Base + 32'(4 * i), {1'($urandom), $urandom}, 7'h0);
        drive(1'b0, 1'b0, 4'h0, Base, 33'h0, 7'h0);

        // Tagged write then read-back
        drive(1'b1, 1'b1, 4'hF, Base + 32'h10, 33'h1_DEAD_BEEF, 7'h0);
        chk("wr_rvalid", 64'(rvalid_a), 64'(1));
        chk("wr_rdata",  64'(rdata_a),  64'(0));
        drive(1'b1, 1'b0, 4'h0, Base + 32'h10, 33'h0, 7'h0);
        chk("rd_rvalid", 64'(rvalid_a), 64'(1));
        chk("rd_rdata",  64'(rdata_a),  64'h1_DEAD_BEEF);
        chk("rd_err",    64'(err_a),    64'(0));
        chk("rd_rintg",  64'(rintg_a),  64'(enc7(32'hDEAD_BEEF)));

        // Partial write clears the tag
        drive(1'b1, 1'b1, 4'b0001, Base + 32'h10, 33'h0_0000_0055, 7'h0);
        drive(1'b1, 1'b0, 4'h0, Base + 32'h10, 33'h0, 7'h0);
        chk("tagclr_rdata", 64'(rdata_a), 64'h0_DEAD_BE55);

        // Out-of-range on both sides, then prior contents intact
        drive(1'b1, 1'b0, 4'h0, 32'h7FFF_FFFC, 33'h0, 7'h0);
        chk("oor_lo_err",   64'(err_a),   64'(1));
        chk("oor_lo_rdata", 64'(rdata_a), 64'(0));
        drive(1'b1, 1'b0, 4'h0, 32'h8000_1000, 33'h0, 7'h0);
        chk("oor_hi_err",   64'(err_a),   64'(1));
        chk("oor_hi_rdata", 64'(rdata_a), 64'(0));
        drive(1'b1, 1'b0, 4'h0, Base + 32'h10, 33'h0, 7'h0);
        chk("oor_after_rdata", 64'(rdata_a), 64'h0_DEAD_BE55);
        chk("oor_after_err",   64'(err_a),   64'(0));

        // Last word of the window is in range
        drive(1'b1, 1'b1, 4'hF, Base + 32'hFFC, 33'h1_CAFE_F00D, 7'h0);
        drive(1'b1, 1'b0, 4'h0, Base + 32'hFFC, 33'h0, 7'h0);
        chk("last_word_rdata", 64'(rdata_a), 64'h1_CAFE_F00D);

        // Bad write integrity: error, no state change
        drive(1'b1, 1'b1, 4'hF, Base + 32'h10, 33'h1_1234_5678, 7'h01);
        chk("badintg_err",   64'(err_a),   64'(1));
        chk("badintg_rdata", 64'(rdata_a), 64'(0));
        drive(1'b1, 1'b0, 4'h0, Base + 32'h10, 33'h0, 7'h0);
        chk("badintg_readback", 64'(rdata_a), 64'h0_DEAD_BE55);

        // Back-to-back reads on C, reset while two responses are in flight
        drive(1'b1, 1'b1, 4'hF, Base + 32'h14, 33'h1_A5A5_0005, 7'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0, Base, 33'h0, 7'h0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 4'h0, Base + 32'(4 * (4 + k)), 33'h0, 7'h0);
        chk("b2b_c_rvalid", 64'(rvalid_c), 64'(1));
        chk("b2b_c_rdata",  64'(rdata_c),  64'h1_A5A5_0005);
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'hF, Base + 32'h14, 33'h1_FFFF_FFFF, 7'h0);
        rst = 1'b0;
        chk("postrst_c_rvalid", 64'(rvalid_c), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'h0, Base, 33'h0, 7'h0);
            chk("postrst_c_quiet", 64'(rvalid_c), 64'(0));
        end
        drive(1'b1, 1'b0, 4'h0, Base + 32'h14, 33'h0, 7'h0);
        chk("postrst_tag_clear", 64'(rdata_a), 64'h0_A5A5_0005);
        drive(1'b0, 1'b0, 4'h0, Base, 33'h0, 7'h0);

        // Grant stall on B: plain, then with stall_i in relative cycles 2-3
        for (int run = 0; run < 2; run++) begin
            gc = -1;
            rc = -1;
            for (int j = 0; j < 12; j++) begin
                req_b   = (gc < 0);
                stall_b = (run == 1) && (j == 2 || j == 3);
                tick();
                if (b_gnt_s === 1'b1 && gc < 0) gc = j;
                if (b_rvalid_s === 1'b1 && rc < 0) begin
                    rc = j;
                    chk("b_err",   64'(b_err_s),   64'(1));
                    chk("b_rdata", 64'(b_rdata_s), 64'(0));
                    chk("b_rintg", 64'(b_intg_s),  64'(enc7(32'h0)));
                end
            end
            chk("b_gnt_cycle",    64'(gc), 64'(run == 1 ? 4 : 2));
            chk("b_rvalid_cycle", 64'(rc), 64'(run == 1 ? 7 : 5));
        end
        req_b   = 1'b0;
        stall_b = 1'b0;

        // Randomised traffic on A/C against the model
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) ra = Base + 32'(4 * $urandom_range(0, 15));
            else if (sel == 8) ra = Base - 32'(4 * $urandom_range(1, 4));
            else ra = Base + 32'h1000 + 32'(4 * $urandom_range(0, 4));
            stall = ($urandom_range(0, 4) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 4'($urandom), ra,
                  {1'($urandom), $urandom},
                  ($urandom_range(0, 9) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h0);
        end
        rst   = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'h0, Base, 33'h0, 7'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
